// File: rtl/eth_tx_frame_ctrl.sv
// Ethernet TX frame sequencer: preamble, payload, pad, FCS and inter-frame gap.
// Define ETH_TX_PAD_EN to zero-pad short frames up to MIN_FRAME_BYTES.
module eth_tx_frame_ctrl #(
  parameter int unsigned IFG_BYTES       = 12,
  parameter int unsigned MIN_FRAME_BYTES = 60
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  output logic       s_axis_tready,
  output logic       preamble_sfd_tx_start,
  input  logic       preamble_sfd_tx_done,
  input  logic [7:0] preamble_data_in,
  output logic       tx_frame_done,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       underrun_err
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE_WAIT = 3'd1,
    S_PREAMBLE = 3'd2,
    S_PAYLOAD  = 3'd3,
`ifdef ETH_TX_PAD_EN
    S_PAD      = 3'd4,
`endif
    S_FCS      = 3'd5,
    S_DRAIN    = 3'd6,
    S_IFG      = 3'd7
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [10:0] cnt_q;
  logic [10:0] cnt_d;
  logic [15:0] step_q;
  logic [15:0] step_d;

  logic [7:0]  txd_q;
  logic [7:0]  txd_d;
  logic        tx_en_q;
  logic        tx_en_d;
  logic        tx_er_q;
  logic        tx_er_d;
  logic        tready_q;
  logic        tready_d;
  logic        start_q;
  logic        start_d;
  logic        done_q;
  logic        done_d;
  logic        under_q;
  logic        under_d;

  logic [10:0] cnt_inc;
  logic [31:0] fcs;
  logic        fcs_last;
  logic        ifg_last;
  logic        last_beat;

  // Reflected CRC-32, one byte per call, LSB first
  function automatic logic [31:0] crc_next(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      if (r[0]) begin
        r = (r >> 1) ^ CRC_POLY;
      end else begin
        r = r >> 1;
      end
    end
    return r;
  endfunction

  // Byte counter saturates so very long frames cannot wrap
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 11'd1;

  assign fcs = ~crc_q;

  // FCS walks steps 0..3 for data; step 4 is the done cycle
  assign fcs_last = (step_q == 16'd4);

  assign ifg_last = (step_q == 16'(IFG_BYTES - 1));

  assign last_beat = s_axis_tvalid & s_axis_tlast;

`ifdef ETH_TX_PAD_EN
  logic pad_needed;

  // True while the frame so far, counting this byte, is still short
  assign pad_needed =
    ({1'b0, cnt_q} + 12'd1) < 12'(MIN_FRAME_BYTES);
`endif

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (s_axis_tvalid) begin
          state_d = S_PRE_WAIT;
        end
      end
      S_PRE_WAIT: begin
        state_d = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        if (preamble_sfd_tx_done) begin
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!s_axis_tvalid) begin
          state_d = S_DRAIN;
        end else if (s_axis_tlast) begin
`ifdef ETH_TX_PAD_EN
          state_d = pad_needed ? S_PAD : S_FCS;
`else
          state_d = S_FCS;
`endif
        end
      end
`ifdef ETH_TX_PAD_EN
      S_PAD: begin
        if (!pad_needed) begin
          state_d = S_FCS;
        end
      end
`endif
      S_FCS: begin
        if (fcs_last) begin
          state_d = S_IFG;
        end
      end
      S_DRAIN: begin
        if (last_beat) begin
          state_d = S_IFG;
        end
      end
      S_IFG: begin
        if (ifg_last) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next values for registered outputs and datapath
  always_comb begin
    txd_d    = 8'h00;
    tx_en_d  = 1'b0;
    tx_er_d  = 1'b0;
    tready_d = 1'b0;
    start_d  = 1'b0;
    done_d   = 1'b0;
    under_d  = 1'b0;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    step_d   = 16'd0;
    unique case (state_q)
      S_IDLE: begin
        start_d = s_axis_tvalid;
      end
      S_PRE_WAIT: begin
      end
      S_PREAMBLE: begin
        txd_d    = preamble_data_in;
        tx_en_d  = 1'b1;
        crc_d    = 32'hFFFF_FFFF;
        cnt_d    = 11'd0;
        tready_d = preamble_sfd_tx_done;
      end
      S_PAYLOAD: begin
        tx_en_d = 1'b1;
        if (s_axis_tvalid) begin
          txd_d    = s_axis_tdata;
          crc_d    = crc_next(crc_q, s_axis_tdata);
          cnt_d    = cnt_inc;
          tready_d = ~s_axis_tlast;
        end else begin
          tx_er_d  = 1'b1;
          under_d  = 1'b1;
          tready_d = 1'b1;
        end
      end
`ifdef ETH_TX_PAD_EN
      S_PAD: begin
        tx_en_d = 1'b1;
        crc_d   = crc_next(crc_q, 8'h00);
        cnt_d   = cnt_inc;
      end
`endif
      S_FCS: begin
        if (fcs_last) begin
          done_d = 1'b1;
        end else begin
          tx_en_d = 1'b1;
          txd_d   = fcs[{step_q[1:0], 3'b000} +: 8];
          step_d  = step_q + 16'd1;
        end
      end
      S_DRAIN: begin
        tready_d = ~last_beat;
        done_d   = last_beat;
      end
      S_IFG: begin
        step_d = step_q + 16'd1;
      end
      default: begin
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      crc_q    <= 32'hFFFF_FFFF;
      cnt_q    <= 11'd0;
      step_q   <= 16'd0;
      txd_q    <= 8'h00;
      tx_en_q  <= 1'b0;
      tx_er_q  <= 1'b0;
      tready_q <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      txd_q    <= txd_d;
      tx_en_q  <= tx_en_d;
      tx_er_q  <= tx_er_d;
      tready_q <= tready_d;
      start_q  <= start_d;
      done_q   <= done_d;
      under_q  <= under_d;
    end
  end

  assign s_axis_tready         = tready_q;
  assign preamble_sfd_tx_start = start_q;
  assign tx_frame_done         = done_q;
  assign gmii_txd              = txd_q;
  assign gmii_tx_en            = tx_en_q;
  assign gmii_tx_er            = tx_er_q;
  assign underrun_err          = under_q;

endmodule

// File: tb/tb_eth_tx_frame_ctrl.sv
// Self-checking bench for eth_tx_frame_ctrl: GMII byte scoreboard from a
// frame-level model, preamble stage model and AXI-Stream source.
`timescale 1ns/1ps
module tb_eth_tx_frame_ctrl;

  localparam int IFG  = 12;
  localparam int MINF = 60;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tready;
  logic       preamble_sfd_tx_start;
  logic       preamble_sfd_tx_done = 1'b0;
  logic [7:0] preamble_data_in = 8'h00;
  logic       tx_frame_done;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       underrun_err;

  always #5 aclk = ~aclk;

  eth_tx_frame_ctrl #(
    .IFG_BYTES      (IFG),
    .MIN_FRAME_BYTES(MINF)
  ) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tready        (s_axis_tready),
    .preamble_sfd_tx_start(preamble_sfd_tx_start),
    .preamble_sfd_tx_done (preamble_sfd_tx_done),
    .preamble_data_in     (preamble_data_in),
    .tx_frame_done        (tx_frame_done),
    .gmii_txd             (gmii_txd),
    .gmii_tx_en           (gmii_tx_en),
    .gmii_tx_er           (gmii_tx_er),
    .underrun_err         (underrun_err)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       l;
  } src_t;

  src_t       src_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] fb[$];
  int         start_cyc[$];
  int         done_cyc[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   en_run = 0;
  int   n_start = 0;
  int   n_done = 0;
  int   n_under = 0;
  int   pre_cnt = 0;
  logic prev_start = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FCS over fb: reflected CRC-32, init all ones, final inversion
  function automatic logic [31:0] ref_fcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (fb[i]) begin
      c = c ^ {24'd0, fb[i]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  task automatic tick();
    src_t s;
    @(posedge aclk);
    #1;
    cyc++;
    if (gmii_tx_en) begin
      en_run++;
      if (exp_q.size() == 0) begin
        chk("tx_en_unexpected", 32'(gmii_tx_en), 32'd0);
      end else begin
        chk("gmii_byte", 32'({gmii_tx_er, gmii_txd}),
            32'(exp_q.pop_front()));
      end
    end else begin
      chk("tx_er_idle", 32'(gmii_tx_er), 32'd0);
    end
    if (tx_frame_done) begin
      n_done++;
      done_cyc.push_back(cyc);
      chk("done_tx_en", 32'(gmii_tx_en), 32'd0);
    end
    if (preamble_sfd_tx_start) begin
      n_start++;
      start_cyc.push_back(cyc);
      chk("start_width", 32'(prev_start), 32'd0);
    end
    prev_start = preamble_sfd_tx_start;
    if (underrun_err) n_under++;
    if (pre_cnt > 0) begin
      preamble_data_in     = (pre_cnt == 1) ? 8'hD5 : 8'h55;
      preamble_sfd_tx_done = (pre_cnt == 1);
      pre_cnt--;
    end else begin
      preamble_data_in     = 8'h00;
      preamble_sfd_tx_done = 1'b0;
    end
    if (preamble_sfd_tx_start) pre_cnt = 8;
    if (src_q.size() > 0) begin
      s = src_q[0];
      s_axis_tvalid = s.v;
      s_axis_tdata  = s.d;
      s_axis_tlast  = s.l;
      if (!s.v || s_axis_tready) void'(src_q.pop_front());
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic clear();
    en_run  = 0;
    n_start = 0;
    n_done  = 0;
    n_under = 0;
    start_cyc.delete();
    done_cyc.delete();
  endtask

  // mode 1 = ASCII "123..." payload, else random bytes.
  // bub > 0 inserts a tvalid gap after that many bytes (underrun).
  task automatic add_frame(input int len, input int mode, input int bub,
                           input bit use_fixed, input logic [31:0] fixed,
                           output int n_en);
    logic [7:0]  pl[$];
    logic [31:0] f;
    for (int i = 0; i < len; i++) begin
      if (mode == 1) pl.push_back(8'(8'h31 + i));
      else pl.push_back(8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < len; i++) begin
      if (bub > 0 && i == bub) src_q.push_back('{1'b0, 8'h00, 1'b0});
      src_q.push_back('{1'b1, pl[i], (i == len - 1)});
    end
    for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    if (bub > 0) begin
      for (int i = 0; i < bub; i++) exp_q.push_back({1'b0, pl[i]});
      exp_q.push_back(9'h100);
      n_en = 8 + bub + 1;
    end else begin
      fb = pl;
`ifdef ETH_TX_PAD_EN
      while (fb.size() < MINF) fb.push_back(8'h00);
`endif
      f = use_fixed ? fixed : ref_fcs();
      foreach (fb[i]) exp_q.push_back({1'b0, fb[i]});
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, f[8*i +: 8]});
      n_en = 8 + fb.size() + 4;
    end
  endtask

  task automatic wait_done(input string tag, input int want,
                           input int budget);
    int k;
    k = 0;
    while (n_done < want && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(n_done >= want), 32'd1);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_tready"}, 32'(s_axis_tready), 32'd0);
    chk({p, "_start"}, 32'(preamble_sfd_tx_start), 32'd0);
    chk({p, "_done"}, 32'(tx_frame_done), 32'd0);
    chk({p, "_txd"}, 32'(gmii_txd), 32'd0);
    chk({p, "_tx_en"}, 32'(gmii_tx_en), 32'd0);
    chk({p, "_tx_er"}, 32'(gmii_tx_er), 32'd0);
    chk({p, "_underrun"}, 32'(underrun_err), 32'd0);
  endtask

  task automatic frame_checks(input string p, input int n_en);
    chk({p, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    chk({p, "_en_cycles"}, 32'(en_run), 32'(n_en));
    chk({p, "_starts"}, 32'(n_start), 32'd1);
    chk({p, "_underrun"}, 32'(n_under), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    int gap;
    int lens[4];
    lens = '{10, 59, 60, 0};

    repeat (3) tick();
    chk_zero("reset");
    aresetn = 1'b1;
    repeat (2) tick();

    clear();
`ifdef ETH_TX_PAD_EN
    add_frame(9, 1, 0, 1'b0, 32'h0, n);
`else
    add_frame(9, 1, 0, 1'b1, 32'hCBF43926, n);
    chk("ascii_en_len", 32'(n), 32'd21);
`endif
    wait_done("ascii_done", 1, 500);
    repeat (IFG + 4) tick();
    frame_checks("ascii", n);

    foreach (lens[j]) begin
      clear();
      add_frame((lens[j] == 0) ? int'($urandom_range(1, 150)) : lens[j],
                0, 0, 1'b0, 32'h0, n);
      wait_done("rnd_done", 1, 1000);
      repeat (IFG + 4) tick();
      frame_checks("rnd", n);
    end

    clear();
    add_frame(100, 0, 0, 1'b0, 32'h0, n);
    add_frame(int'($urandom_range(20, 80)), 0, 0, 1'b0, 32'h0, n2);
    wait_done("b2b_done", 2, 2000);
    repeat (IFG + 4) tick();
    chk("b2b_exp_left", 32'(exp_q.size()), 32'd0);
    chk("b2b_en_cycles", 32'(en_run), 32'(n + n2));
    chk("b2b_starts", 32'(start_cyc.size()), 32'd2);
    gap = (start_cyc.size() > 1 && done_cyc.size() > 0) ?
          start_cyc[1] - done_cyc[0] : -1;
    chk("b2b_ifg_gap", 32'(gap), 32'(IFG + 1));

    clear();
    add_frame(12, 0, 5, 1'b0, 32'h0, n);
    wait_done("urun_done", 1, 1000);
    repeat (IFG + 4) tick();
    chk("urun_exp_left", 32'(exp_q.size()), 32'd0);
    chk("urun_en_cycles", 32'(en_run), 32'(n));
    chk("urun_pulses", 32'(n_under), 32'd1);
    chk("urun_drained", 32'(src_q.size()), 32'd0);
    chk("urun_dones", 32'(n_done), 32'd1);

    clear();
    add_frame(20, 0, 0, 1'b0, 32'h0, n);
    for (int k = 0; k < 1000 && en_run < n - 1; k++) tick();
    chk("rst_reach_fcs2", 32'(en_run), 32'(n - 1));
    aresetn = 1'b0;
    tick();
    chk_zero("midrst");
    aresetn = 1'b1;
    exp_q.delete();
    src_q.delete();
    pre_cnt = 0;
    repeat (3) tick();
    chk("midrst_no_done", 32'(n_done), 32'd0);

    clear();
    add_frame(int'($urandom_range(1, 120)), 0, 0, 1'b0, 32'h0, n);
    wait_done("after_rst_done", 1, 1000);
    repeat (IFG + 4) tick();
    frame_checks("after_rst", n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
